// File: rtl/lobster_pkg.sv
// Shared definitions for the lobster data-bus arbiter: FSM state encoding,
// requester IDs and the SRAM data width.
package lobster_pkg;

    localparam int unsigned DATA_WIDTH = 64;

    typedef logic [1:0] state_t;
    localparam state_t IDLE   = 2'd0;
    localparam state_t ACCESS = 2'd1;
    localparam state_t RESP   = 2'd2;

    typedef logic req_id_t;
    localparam req_id_t REQ_FETCH = 1'b0;
    localparam req_id_t REQ_DATA  = 1'b1;

endpackage

// File: rtl/lobster_dbus_arbiter_if.sv
// Bundle of the fetch, data and SRAM-side signals of the lobster data-bus
// arbiter. The arbiter uses the slave modport; the surrounding system
// (requesters and SRAM) uses the master modport.
interface lobster_dbus_arbiter_if
    import lobster_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 36
);
    // Fetch requester
    logic                  f_req;
    logic [ADDR_WIDTH-1:0] f_addr;
    logic [DATA_WIDTH-1:0] f_rdata;
    logic                  f_done;
    logic                  f_err;

    // Load/store requester
    logic                  d_req;
    logic                  d_we;
    logic [ADDR_WIDTH-1:0] d_addr;
    logic [DATA_WIDTH-1:0] d_wdata;
    logic [DATA_WIDTH-1:0] d_rdata;
    logic                  d_done;
    logic                  d_err;

    // SRAM side
    logic                  ce;
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  rdy;

    modport slave (
        input  f_req, f_addr, d_req, d_we, d_addr, d_wdata, rdata, rdy,
        output f_rdata, f_done, f_err, d_rdata, d_done, d_err, ce, we, addr, wdata
    );

    modport master (
        output f_req, f_addr, d_req, d_we, d_addr, d_wdata, rdata, rdy,
        input  f_rdata, f_done, f_err, d_rdata, d_done, d_err, ce, we, addr, wdata
    );

endinterface

// File: rtl/lobster_rr_pick.sv
// Two-way round-robin select between the fetch and data requesters.
// On a tie the requester that was not granted last wins.
module lobster_rr_pick
    import lobster_pkg::*;
(
    input  logic    f_req,
    input  logic    d_req,
    input  req_id_t last,
    output logic    valid,
    output req_id_t id
);

    // Pick the single pending requester, or alternate on a tie
    always_comb begin
        valid = f_req | d_req;
        if (f_req && d_req) begin
            id = (last == REQ_DATA) ? REQ_FETCH : REQ_DATA;
        end else if (d_req) begin
            id = REQ_DATA;
        end else begin
            id = REQ_FETCH;
        end
    end

endmodule

// File: rtl/lobster_dbus_arbiter.sv
// Arbiter sharing one SRAM port between the fetch and load/store requesters.
// One transaction at a time: IDLE (grant) -> ACCESS (wait for rdy) -> RESP
// (done pulse). Optional ACCESS timeout enabled by LOBSTER_DBUS_TIMEOUT_EN.
module lobster_dbus_arbiter
    import lobster_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 36,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input logic                   clk,
    input logic                   rst,
    lobster_dbus_arbiter_if.slave bus
);

    if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    state_t                state_q, state_d;
    logic                  ce_q, ce_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] f_rdata_q, f_rdata_d;
    logic [DATA_WIDTH-1:0] d_rdata_q, d_rdata_d;
    logic                  f_done_q, f_done_d;
    logic                  d_done_q, d_done_d;
    // Current grant; after the transaction it doubles as the last-granted pointer
    req_id_t               gnt_q, gnt_d;

    logic                  pick_valid;
    req_id_t               pick_id;
    logic                  timeout;
    logic                  finish;
    logic [DATA_WIDTH-1:0] rsp_data;

    lobster_rr_pick u_rr_pick (
        .f_req (bus.f_req),
        .d_req (bus.d_req),
        .last  (gnt_q),
        .valid (pick_valid),
        .id    (pick_id)
    );

    assign finish   = (state_q == ACCESS) && (bus.rdy || timeout);
    // An aborted access returns zero data
    assign rsp_data = bus.rdy ? bus.rdata : '0;

    // Next-state, SRAM command and response registers
    always_comb begin
        state_d   = state_q;
        ce_d      = ce_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        gnt_d     = gnt_q;
        f_rdata_d = f_rdata_q;
        d_rdata_d = d_rdata_q;
        f_done_d  = 1'b0;
        d_done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d = ACCESS;
                    ce_d    = 1'b1;
                    gnt_d   = pick_id;
                    if (pick_id == REQ_DATA) begin
                        we_d    = bus.d_we;
                        addr_d  = bus.d_addr;
                        wdata_d = bus.d_wdata;
                    end else begin
                        we_d    = 1'b0;
                        addr_d  = bus.f_addr;
                        wdata_d = '0;
                    end
                end
            end
            ACCESS: begin
                if (finish) begin
                    state_d = RESP;
                    ce_d    = 1'b0;
                    we_d    = 1'b0;
                    if (gnt_q == REQ_DATA) begin
                        d_done_d  = 1'b1;
                        d_rdata_d = rsp_data;
                    end else begin
                        f_done_d  = 1'b1;
                        f_rdata_d = rsp_data;
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers; reset aborts any transaction in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            ce_q      <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            gnt_q     <= REQ_FETCH;  // first tie goes to data
            f_rdata_q <= '0;
            d_rdata_q <= '0;
            f_done_q  <= 1'b0;
            d_done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            ce_q      <= ce_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            gnt_q     <= gnt_d;
            f_rdata_q <= f_rdata_d;
            d_rdata_q <= d_rdata_d;
            f_done_q  <= f_done_d;
            d_done_q  <= d_done_d;
        end
    end

`ifdef LOBSTER_DBUS_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q;
    logic             f_err_q;
    logic             d_err_q;

    // Last allowed ACCESS cycle is reached without rdy
    assign timeout = (state_q == ACCESS) && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    // Count ACCESS cycles; flag err alongside done when the budget runs out
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            f_err_q <= 1'b0;
            d_err_q <= 1'b0;
        end else begin
            f_err_q <= 1'b0;
            d_err_q <= 1'b0;
            if ((state_q == ACCESS) && !bus.rdy) begin
                if (timeout) begin
                    cnt_q <= '0;
                    if (gnt_q == REQ_DATA) begin
                        d_err_q <= 1'b1;
                    end else begin
                        f_err_q <= 1'b1;
                    end
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end else begin
                cnt_q <= '0;
            end
        end
    end

    assign bus.f_err = f_err_q;
    assign bus.d_err = d_err_q;
`else
    assign timeout   = 1'b0;
    assign bus.f_err = 1'b0;
    assign bus.d_err = 1'b0;
`endif

    assign bus.ce      = ce_q;
    assign bus.we      = we_q;
    assign bus.addr    = addr_q;
    assign bus.wdata   = wdata_q;
    assign bus.f_rdata = f_rdata_q;
    assign bus.d_rdata = d_rdata_q;
    assign bus.f_done  = f_done_q;
    assign bus.d_done  = d_done_q;

endmodule

// File: tb/tb_lobster_dbus_arbiter.sv
// Self-checking bench for lobster_dbus_arbiter: directed scenarios plus
// randomized two-requester traffic against a transaction-level schedule model.
module tb_lobster_dbus_arbiter;
    import lobster_pkg::*;

    localparam int unsigned AW = 36;
    localparam int unsigned TO = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    lobster_dbus_arbiter_if #(.ADDR_WIDTH(AW)) bus ();

    lobster_dbus_arbiter #(
        .ADDR_WIDTH     (AW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got running want finished");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom(), $urandom()};
    endfunction

    function automatic logic [AW-1:0] rnd_addr();
        logic [63:0] t;
        t = {$urandom(), $urandom()};
        return t[AW-1:0];
    endfunction

    task automatic idle_inputs();
        bus.f_req   = 1'b0;
        bus.f_addr  = '0;
        bus.d_req   = 1'b0;
        bus.d_we    = 1'b0;
        bus.d_addr  = '0;
        bus.d_wdata = '0;
        bus.rdata   = '0;
        bus.rdy     = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        bus.rdy = 1'b1;
        bus.f_req = 1'b1;
        tick();
        tick();
        n_vec++; if (bus.ce !== 1'b0) begin n_err++; $display("FAIL reset_ce: got %0h want 0", bus.ce); end
        n_vec++; if (bus.we !== 1'b0) begin n_err++; $display("FAIL reset_we: got %0h want 0", bus.we); end
        n_vec++; if (bus.addr !== '0) begin n_err++; $display("FAIL reset_addr: got %0h want 0", bus.addr); end
        n_vec++; if (bus.wdata !== '0) begin n_err++; $display("FAIL reset_wdata: got %0h want 0", bus.wdata); end
        n_vec++; if ({bus.f_done, bus.d_done} !== 2'b00) begin
            n_err++; $display("FAIL reset_done: got %b want 00", {bus.f_done, bus.d_done});
        end
        n_vec++; if ({bus.f_err, bus.d_err} !== 2'b00) begin
            n_err++; $display("FAIL reset_err: got %b want 00", {bus.f_err, bus.d_err});
        end
        n_vec++; if (bus.f_rdata !== '0) begin n_err++; $display("FAIL reset_f_rdata: got %0h want 0", bus.f_rdata); end
        n_vec++; if (bus.d_rdata !== '0) begin n_err++; $display("FAIL reset_d_rdata: got %0h want 0", bus.d_rdata); end
        idle_inputs();
        rst = 1'b0;
    endtask

    task automatic test_fetch();
        bus.f_req  = 1'b1;
        bus.f_addr = AW'(36'hF800);
        tick();  // first ACCESS cycle
        n_vec++; if ({bus.ce, bus.we} !== 2'b10) begin n_err++; $display("FAIL fetch_cmd: got %b want 10", {bus.ce, bus.we}); end
        n_vec++; if (bus.addr !== AW'(36'hF800)) begin n_err++; $display("FAIL fetch_addr: got %0h want f800", bus.addr); end
        bus.rdy   = 1'b1;
        bus.rdata = 64'h1122334455667788;
        tick();  // RESP
        n_vec++; if ({bus.f_done, bus.d_done, bus.ce} !== 3'b100) begin
            n_err++; $display("FAIL fetch_done: got %b want 100", {bus.f_done, bus.d_done, bus.ce});
        end
        n_vec++; if (bus.f_rdata !== 64'h1122334455667788) begin
            n_err++; $display("FAIL fetch_rdata: got %0h want 1122334455667788", bus.f_rdata);
        end
        bus.f_req = 1'b0;
        bus.rdata = rnd64();
        tick();  // IDLE, rdy must be ignored here
        bus.rdy = 1'b0;
        n_vec++; if ({bus.f_done, bus.ce} !== 2'b00) begin
            n_err++; $display("FAIL fetch_after: got %b want 00", {bus.f_done, bus.ce});
        end
        n_vec++; if (bus.f_rdata !== 64'h1122334455667788) begin
            n_err++; $display("FAIL fetch_rdata_hold: got %0h want 1122334455667788", bus.f_rdata);
        end
    endtask

    task automatic test_store_wait();
        logic [63:0] rd;
        int          dones;
        rd = rnd64();
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b1;
        bus.d_addr  = AW'(36'h100);
        bus.d_wdata = 64'hDEAD;
        bus.rdy     = 1'b0;
        tick();  // first ACCESS cycle
        for (int i = 0; i < 5; i++) begin
            n_vec++;
            if ({bus.ce, bus.we, bus.addr, bus.wdata, bus.d_done} !== {2'b11, AW'(36'h100), 64'hDEAD, 1'b0}) begin
                n_err++;
                $display("FAIL store_hold[%0d]: got ce=%0h we=%0h addr=%0h wdata=%0h done=%0h want 1 1 100 dead 0",
                         i, bus.ce, bus.we, bus.addr, bus.wdata, bus.d_done);
            end
            if (i == 4) begin
                bus.rdy   = 1'b1;
                bus.rdata = rd;
            end
            tick();
        end
        n_vec++; if ({bus.d_done, bus.f_done, bus.ce, bus.we} !== 4'b1000) begin
            n_err++; $display("FAIL store_done: got %b want 1000", {bus.d_done, bus.f_done, bus.ce, bus.we});
        end
        n_vec++; if (bus.d_rdata !== rd) begin n_err++; $display("FAIL store_rdata: got %0h want %0h", bus.d_rdata, rd); end
        bus.d_req = 1'b0;
        bus.rdy   = 1'b0;
        dones = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            dones += int'(bus.d_done) + int'(bus.f_done) + int'(bus.ce);
        end
        n_vec++; if (dones != 0) begin n_err++; $display("FAIL store_quiet: got %0d activity want 0", dones); end
    endtask

    // Random traffic; the model schedules each transaction from the IDLE
    // cycle it is granted in: ACCESS for w+1 cycles, done next, idle after.
    task automatic test_traffic(input bit contention, input int n_trans);
        int          c, next_free, acc_lo, acc_hi, done_cyc, w, finished;
        req_id_t     last, g;
        logic        exp_we, in_acc;
        logic [AW-1:0] exp_addr;
        logic [63:0] exp_wdata, exp_rdata, m_f_rdata, m_d_rdata;
        req_id_t     obs[$];
        req_id_t     want_ord[4];
        do_reset();
        c = 0; next_free = 0; acc_lo = -1; acc_hi = -1; done_cyc = -1; finished = 0;
        last = REQ_FETCH; g = REQ_FETCH;
        exp_we = 1'b0; exp_addr = '0; exp_wdata = '0; exp_rdata = '0;
        m_f_rdata = '0; m_d_rdata = '0;
        while (finished < n_trans && c < 3000) begin
            in_acc = (c >= acc_lo) && (c <= acc_hi);
            n_vec++; if (bus.ce !== in_acc) begin
                n_err++; $display("FAIL traffic_ce @%0d: got %0h want %0h", c, bus.ce, in_acc);
            end
            if (in_acc) begin
                n_vec++; if ({bus.we, bus.addr} !== {exp_we, exp_addr}) begin
                    n_err++; $display("FAIL traffic_cmd @%0d: got we=%0h addr=%0h want we=%0h addr=%0h",
                                      c, bus.we, bus.addr, exp_we, exp_addr);
                end
                if (g == REQ_DATA) begin
                    n_vec++; if (bus.wdata !== exp_wdata) begin
                        n_err++; $display("FAIL traffic_wdata @%0d: got %0h want %0h", c, bus.wdata, exp_wdata);
                    end
                end
            end
            if (c == done_cyc) begin
                if (g == REQ_DATA) m_d_rdata = exp_rdata;
                else m_f_rdata = exp_rdata;
                finished++;
            end
            if (bus.f_done || bus.d_done) obs.push_back(bus.d_done ? REQ_DATA : REQ_FETCH);
            n_vec++; if ({bus.f_done, bus.d_done} !== {(c == done_cyc) && (g == REQ_FETCH), (c == done_cyc) && (g == REQ_DATA)}) begin
                n_err++; $display("FAIL traffic_done @%0d: got %b want fetch=%0d data=%0d", c,
                                  {bus.f_done, bus.d_done}, (c == done_cyc) && (g == REQ_FETCH), (c == done_cyc) && (g == REQ_DATA));
            end
            n_vec++; if ((bus.f_rdata !== m_f_rdata) || (bus.d_rdata !== m_d_rdata)) begin
                n_err++; $display("FAIL traffic_rdata @%0d: got %0h/%0h want %0h/%0h", c,
                                  bus.f_rdata, bus.d_rdata, m_f_rdata, m_d_rdata);
            end
            n_vec++; if ({bus.f_err, bus.d_err} !== 2'b00) begin
                n_err++; $display("FAIL traffic_err @%0d: got %b want 00", c, {bus.f_err, bus.d_err});
            end
            // requesters: drop in the done cycle, otherwise maybe raise a new request
            if ((c == done_cyc) && (g == REQ_FETCH)) bus.f_req = 1'b0;
            else if (!bus.f_req && (contention || $urandom_range(2) == 0)) begin
                bus.f_req  = 1'b1;
                bus.f_addr = rnd_addr();
            end
            if ((c == done_cyc) && (g == REQ_DATA)) bus.d_req = 1'b0;
            else if (!bus.d_req && (contention || $urandom_range(2) == 0)) begin
                bus.d_req   = 1'b1;
                bus.d_we    = 1'($urandom_range(1));
                bus.d_addr  = rnd_addr();
                bus.d_wdata = rnd64();
            end
            // arbitration in a free cycle
            if ((c >= next_free) && (bus.f_req || bus.d_req)) begin
                if (bus.f_req && bus.d_req) g = (last == REQ_DATA) ? REQ_FETCH : REQ_DATA;
                else g = bus.d_req ? REQ_DATA : REQ_FETCH;
                last = g;
                w = contention ? 0 : int'($urandom_range(3));
                acc_lo = c + 1; acc_hi = c + 1 + w; done_cyc = c + 2 + w; next_free = c + 3 + w;
                exp_we    = (g == REQ_DATA) ? bus.d_we : 1'b0;
                exp_addr  = (g == REQ_DATA) ? bus.d_addr : bus.f_addr;
                exp_wdata = bus.d_wdata;
            end
            // SRAM: rdy only on the chosen last ACCESS cycle, noise elsewhere
            bus.rdata = rnd64();
            if (c == acc_hi) begin
                bus.rdy   = 1'b1;
                exp_rdata = bus.rdata;
            end else if ((c >= acc_lo) && (c < acc_hi)) begin
                bus.rdy = 1'b0;
            end else begin
                bus.rdy = 1'($urandom_range(1));
            end
            tick();
            c++;
        end
        n_vec++; if (finished != n_trans) begin
            n_err++; $display("FAIL traffic_progress: got %0d transactions want %0d", finished, n_trans);
        end
        if (contention) begin
            want_ord[0] = REQ_DATA; want_ord[1] = REQ_FETCH;
            want_ord[2] = REQ_DATA; want_ord[3] = REQ_FETCH;
            for (int i = 0; i < 4; i++) begin
                n_vec++;
                if ((obs.size() <= i) || (obs[i] !== want_ord[i])) begin
                    n_err++; $display("FAIL contention_order[%0d]: got %0h want %0h", i,
                                      (obs.size() > i) ? obs[i] : 1'bx, want_ord[i]);
                end
            end
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid_access();
        logic [AW-1:0] fa;
        int            act;
        do_reset();
        bus.d_req  = 1'b1;
        bus.d_addr = rnd_addr();
        tick();  // ACCESS 1
        n_vec++; if (bus.ce !== 1'b1) begin n_err++; $display("FAIL midrst_ce_on: got %0h want 1", bus.ce); end
        tick();  // ACCESS 2
        rst = 1'b1;
        tick();
        n_vec++; if ({bus.ce, bus.f_done, bus.d_done} !== 3'b000) begin
            n_err++; $display("FAIL midrst_abort: got %b want 000", {bus.ce, bus.f_done, bus.d_done});
        end
        rst = 1'b0;
        bus.d_req = 1'b0;
        bus.rdy   = 1'b1;
        act = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            act += int'(bus.ce) + int'(bus.d_done) + int'(bus.f_done);
        end
        n_vec++; if (act != 0) begin n_err++; $display("FAIL midrst_quiet: got %0d activity want 0", act); end
        fa = rnd_addr();
        bus.rdy    = 1'b0;
        bus.f_req  = 1'b1;
        bus.f_addr = fa;
        tick();
        n_vec++; if ({bus.ce, bus.addr} !== {1'b1, fa}) begin
            n_err++; $display("FAIL midrst_idle: got ce=%0h addr=%0h want 1 %0h", bus.ce, bus.addr, fa);
        end
        bus.rdy = 1'b1;
        tick();
        idle_inputs();
        tick();
    endtask

    task automatic test_timeout();
        int bad;
        do_reset();
`ifdef LOBSTER_DBUS_TIMEOUT_EN
        bus.f_req  = 1'b1;
        bus.f_addr = rnd_addr();
        tick();
        bus.rdy   = 1'b1;
        bus.rdata = 64'hA5A5_0000_1234_5678;
        tick();
        n_vec++; if ({bus.f_done, bus.f_err} !== 2'b10) begin
            n_err++; $display("FAIL to_prefetch: got %b want 10", {bus.f_done, bus.f_err});
        end
        bus.f_req = 1'b0;
        bus.rdy   = 1'b0;
        tick();
        bus.f_req = 1'b1;
        tick();  // ACCESS 1
        bad = 0;
        for (int i = 0; i < int'(TO); i++) begin
            if ({bus.ce, bus.f_done, bus.f_err} !== 3'b100) bad++;
            tick();
        end
        n_vec++; if (bad != 0) begin n_err++; $display("FAIL to_access: got %0d bad cycles want 0", bad); end
        n_vec++; if ({bus.f_done, bus.f_err, bus.ce, bus.d_done, bus.d_err} !== 5'b11000) begin
            n_err++; $display("FAIL to_abort: got %b want 11000", {bus.f_done, bus.f_err, bus.ce, bus.d_done, bus.d_err});
        end
        n_vec++; if (bus.f_rdata !== '0) begin n_err++; $display("FAIL to_rdata: got %0h want 0", bus.f_rdata); end
        bus.f_req = 1'b0;
        tick();
        n_vec++; if ({bus.f_done, bus.f_err} !== 2'b00) begin
            n_err++; $display("FAIL to_after: got %b want 00", {bus.f_done, bus.f_err});
        end
`else
        bus.f_req = 1'b1;
        bus.rdy   = 1'b0;
        tick();
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            if ({bus.ce, bus.f_done, bus.f_err} !== 3'b100) bad++;
            tick();
        end
        n_vec++; if (bad != 0) begin n_err++; $display("FAIL no_timeout_wait: got %0d bad cycles want 0", bad); end
        do_reset();
`endif
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_fetch();
        test_store_wait();
        test_reset();
        test_traffic(1'b1, 4);
        test_traffic(1'b0, 200);
        test_reset_mid_access();
        test_timeout();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/lobster_dbus_arbiter.md
LOBSTER_DBUS_ARBITER -- requirements
Module: lobster_dbus_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 36, meaning SRAM address width.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 255, meaning the ACCESS cycles allowed before abort (used only under LOBSTER_DBUS_TIMEOUT_EN).
REQ-003 SHALL have port clk, input, width 1, the clock; all logic on the posedge.
REQ-004 SHALL have port rst, input, width 1, synchronous active-high reset.
REQ-005 SHALL have ports f_req in 1 (fetch request), f_addr in ADDR_WIDTH, f_rdata out 64, f_done out 1, f_err out 1.
REQ-006 SHALL have ports d_req in 1 (load/store request), d_we in 1 (1=store), d_addr in ADDR_WIDTH, d_wdata in 64, d_rdata out 64, d_done out 1, d_err out 1.
REQ-007 SHALL have ports ce out 1, we out 1, addr out ADDR_WIDTH, wdata out 64, rdata in 64, rdy in 1 (SRAM side).

Function
REQ-008 SHALL implement FSM states IDLE, ACCESS, RESP; IDLE->ACCESS on any request; ACCESS->RESP on rdy=1 (or timeout); RESP->IDLE unconditionally.
REQ-009 SHALL grant in IDLE, one requester per transaction: with only one request pending, grant it; with both pending, grant the requester not granted last (round-robin); the first tie after reset goes to data.
REQ-010 SHALL register ce=1, we (=d_we for data, 0 for fetch), addr and wdata at the IDLE->ACCESS edge, and hold them stable throughout ACCESS.
REQ-011 SHALL sample rdata on the edge at which rdy=1 in ACCESS into the granted requester's rdata register, and deassert ce/we on that same edge.
REQ-012 SHALL pulse the granted requester's done for exactly the one RESP cycle; rdata SHALL stay valid until that requester's next done.
REQ-013 SHALL, for a store, set d_rdata to the rdata sampled at completion, don't-care for the requester.
REQ-014 Requesters SHALL hold req/addr/data stable until done and drop req in the done cycle; req high in the following IDLE cycle is a new request.
REQ-015 Minimum latency SHALL be 3 cycles from req sampled in IDLE to done (rdy high during the first ACCESS cycle); throughput is one transaction per 3 cycles.
REQ-016 SHALL ignore rdy outside ACCESS and requests outside IDLE.
REQ-017 SHALL never assert f_done and d_done in the same cycle; done/err outputs SHALL be registered.

Reset
REQ-018 SHALL on rst drive state=IDLE, ce=0, we=0, addr=0, wdata=0, f_done=d_done=0, f_err=d_err=0, f_rdata=d_rdata=0, round-robin pointer=data-first, timeout counter=0.
REQ-019 rst during ACCESS or RESP SHALL abort the transaction without a done pulse; ce SHALL be 0 the cycle after rst is sampled.

Configuration
REQ-020 With LOBSTER_DBUS_TIMEOUT_EN defined, an up-counter SHALL count ACCESS cycles; on reaching TIMEOUT_CYCLES without rdy, go to RESP with ce=0, the requester's rdata=0, err=1 together with done.
REQ-021 Without LOBSTER_DBUS_TIMEOUT_EN, ACCESS SHALL wait indefinitely for rdy, with no counter logic, and f_err/d_err tied to 0.

Structure
REQ-022 SHALL place the state enum (IDLE/ACCESS/RESP) and the requester-ID constants (REQ_FETCH, REQ_DATA) in shared package lobster_pkg.
REQ-023 SHALL be a single module; an optional sub-module lobster_rr_pick (2-way round-robin select) is permitted.

Verification
REQ-024 Fetch only: f_req=1, f_addr=0xF800, rdy high in the first ACCESS cycle, rdata=0x1122334455667788 -> ce=1/we=0/addr=0xF800 for 1 cycle; f_done pulses 3 cycles after req; f_rdata=0x1122334455667788.
REQ-025 Store with wait: d_req=1, d_we=1, d_addr=0x100, d_wdata=0xDEAD, rdy low for 4 ACCESS cycles -> we=1 and wdata=0xDEAD stable for 5 cycles; d_done pulses once.
REQ-026 Contention: f_req and d_req held high, each dropped at its done and re-raised in the next IDLE cycle, for 4 transactions -> grant order data, fetch, data, fetch; dones never coincide.
REQ-027 Reset mid-ACCESS: rst asserted on the second ACCESS cycle -> ce=0 the next cycle, no done, state IDLE.
REQ-028 Timeout (LOBSTER_DBUS_TIMEOUT_EN, TIMEOUT_CYCLES=8): rdy held low -> after 8 ACCESS cycles f_done=1 with f_err=1 and f_rdata=0; without the macro, ce stays high for 100 cycles.
